psram_init_seq: RTL

Power-up sequencer that sits between the PSRAM controller and the QSPI pads. After reset it owns the pins. It waits out the device power-on time, then issues the SPI reset pair: Reset-Enable 0x66, then Reset 0x99. After that it hands the pins to the controller's sck/ce_n/dout/douten. `ready` gates AHB traffic at the top level until the device is initialised.

---
 rtl/psram_pkg.sv | 19 +
 rtl/psram_spi_byte_tx.sv | 75 +++++++
 rtl/psram_init_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: opcodes, SPI phase width and the init sequencer state type.
package psram_pkg;

    localparam logic [7:0] CMD_RSTEN  = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;

    // 16 phases per byte: 8 bits, 2 HCLK per bit
    localparam int unsigned PHASE_W = 4;

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_CMD  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } init_state_e;

endpackage

// File: rtl/psram_spi_byte_tx.sv
// Single-line SPI mode-0 byte transmitter, MSB first, 2 clk per bit, registered sck/sdo.
module psram_spi_byte_tx
    import psram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       sck,
    output logic       sdo,
    output logic       done
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(15);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               active_q, active_d;
    logic [7:0]         byte_q, byte_d;
    logic               sck_q, sck_d;
    logic               sdo_q, sdo_d;
    logic               done_q, done_d;
    logic [2:0]         bit_idx;

    // Phase sequencing; pin values computed from the phase being entered so they are registered
    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        byte_d   = byte_q;
        sck_d    = 1'b0;
        sdo_d    = 1'b0;
        done_d   = 1'b0;
        bit_idx  = 3'(3'd7 - phase_q[3:1]);
        if (start) begin
            active_d = 1'b1;
            phase_d  = '0;
            byte_d   = tx_byte;
        end else if (active_q) begin
            if (phase_q == PHASE_LAST) begin
                active_d = 1'b0;
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
        if (active_d) begin
            bit_idx = 3'(3'd7 - phase_d[3:1]);
            sck_d   = phase_d[0];
            sdo_d   = byte_d[bit_idx];
            done_d  = (phase_d == PHASE_LAST);
        end
    end

    // Transmitter state and pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            active_q <= 1'b0;
            byte_q   <= '0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            byte_q   <= byte_d;
            sck_q    <= sck_d;
            sdo_q    <= sdo_d;
            done_q   <= done_d;
        end
    end

    assign sck  = sck_q;
    assign sdo  = sdo_q;
    assign done = done_q;

endmodule

// File: rtl/psram_init_seq.sv
// PSRAM power-up sequencer: POR wait, Reset-Enable + Reset commands, then hands pads to controller.
module psram_init_seq
    import psram_pkg::*;
#(
    parameter int unsigned POR_WAIT = 7500,
    parameter int unsigned CE_GAP   = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       reinit,
    input  logic       ctrl_sck,
    input  logic       ctrl_ce_n,
    input  logic [3:0] ctrl_dout,
    input  logic [3:0] ctrl_douten,
    output logic       ready,
    output logic       busy,
    output logic       sck,
    output logic       ce_n,
    output logic [3:0] dout,
    output logic [3:0] douten
);

    localparam int unsigned POR_W = $clog2(POR_WAIT + 1);
    localparam int unsigned GAP_W = $clog2(CE_GAP + 1);

    init_state_e      state_q, state_d;
    logic [POR_W-1:0] por_cnt_q, por_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             idx_q, idx_d;
    logic             ce_n_q, ce_n_d;
    logic [3:0]       douten_q, douten_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_sck;
    logic             tx_sdo;
    logic             tx_done;

    psram_spi_byte_tx u_tx (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .start   (tx_start),
        .tx_byte (tx_byte),
        .sck     (tx_sck),
        .sdo     (tx_sdo),
        .done    (tx_done)
    );

    // State, counters and registered pin/status values
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_POR;
            por_cnt_q <= POR_W'(POR_WAIT);
            gap_cnt_q <= '0;
            idx_q     <= 1'b0;
            ce_n_q    <= 1'b1;
            douten_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            por_cnt_q <= por_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            ce_n_q    <= ce_n_d;
            douten_q  <= douten_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Next state; a byte transfer is launched on every entry into CMD
    always_comb begin
        state_d   = state_q;
        por_cnt_d = por_cnt_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        tx_start  = 1'b0;
        case (state_q)
            ST_POR: begin
                if (por_cnt_q == '0) begin
                    state_d  = ST_CMD;
                    idx_d    = 1'b0;
                    tx_start = 1'b1;
                end else begin
                    por_cnt_d = por_cnt_q - POR_W'(1);
                end
            end
            ST_CMD: begin
                if (tx_done) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_W'(CE_GAP - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (!idx_q) begin
                        state_d  = ST_CMD;
                        idx_d    = 1'b1;
                        tx_start = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                if (reinit) begin
                    state_d  = ST_CMD;
                    idx_d    = 1'b0;
                    tx_start = 1'b1;
                end
            end
            default: state_d = ST_POR;
        endcase
        tx_byte = idx_d ? CMD_RST : CMD_RSTEN;
    end

    // Pin and status values for the state being entered
    always_comb begin
        ce_n_d   = 1'b1;
        douten_d = 4'b0000;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        case (state_d)
            ST_CMD: begin
                ce_n_d   = 1'b0;
                douten_d = 4'b0001;
                busy_d   = 1'b1;
            end
            ST_GAP:  busy_d  = 1'b1;
            ST_DONE: ready_d = 1'b1;
            default: ;
        endcase
    end

    // Pad mux: controller owns the pins once the sequence is complete
    assign sck    = ready_q ? ctrl_sck    : tx_sck;
    assign ce_n   = ready_q ? ctrl_ce_n   : ce_n_q;
    assign dout   = ready_q ? ctrl_dout   : {3'b000, tx_sdo};
    assign douten = ready_q ? ctrl_douten : douten_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule
